// File: rtl/krz_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling into a first-word-fall-through receive FIFO.
// Latency: byte visible one cycle after the stop-bit sample; a full FIFO without a same-cycle pop drops the byte and sets overrun.
module krz_uart_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  div,
  input  logic                         RX,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         frame_err,
  output logic                         overrun,
  input  logic                         err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s;
  logic [15:0]   div_q, div_n;
  logic [15:0]   tick_cnt, tick_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          push, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, wr_en, ovr_set;

  // Synchronizer resets high so a line held low after reset is not mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_q    <= 16'd0;
      tick_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      state    <= state_n;
      div_q    <= div_n;
      tick_cnt <= tick_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
    end
  end

  always_comb begin
    state_n  = state;
    div_n    = div_q;
    tick_n   = tick_cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        // Half a bit period to land the start-bit check in mid-bit.
        if (!rx_s) begin
          div_n   = div;
          tick_n  = div >> 1;
          state_n = START;
        end
      end
      START: begin
        if (tick_cnt != 16'd0) begin
          tick_n = tick_cnt - 16'd1;
        end else if (!rx_s) begin
          tick_n  = div_q;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (tick_cnt != 16'd0) begin
          tick_n = tick_cnt - 16'd1;
        end else begin
          shift_n = {rx_s, shift[7:1]};
          tick_n  = div_q;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (tick_cnt != 16'd0) begin
          tick_n = tick_cnt - 16'd1;
        end else if (rx_s) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_n  = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign rx_valid = (count != CW'(0));
  assign pop      = rx_valid & rx_ready;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign wr_en    = push & (~full | pop);
  assign ovr_set  = push & full & ~pop;
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      frame_err <= ferr_set | (frame_err & ~err_clr);
      overrun   <= ovr_set  | (overrun   & ~err_clr);
    end
  end

endmodule

// File: doc/krz_uart_rx.md
KRZ_UART_RX -- requirements
Module: krz_uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, >=2.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port div  input  16  clocks per bit minus 1; legal range 3..65535; sampled only in IDLE.
REQ-005 SHALL have port RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data  output  8  byte at FIFO head.
REQ-007 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port rx_ready  input  1  consumer accept; pop when rx_valid & rx_ready.
REQ-009 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port frame_err  output  1  sticky framing-error flag.
REQ-011 SHALL have port overrun  output  1  sticky overrun flag.
REQ-012 SHALL have port err_clr  input  1  one-cycle pulse clearing frame_err and overrun.

Function
REQ-013 SHALL pass RX through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE, with a 16-bit down-counter tick_cnt and 3-bit bit index.
REQ-015 IDLE: when rx_s==0, SHALL latch div, load tick_cnt = div>>1, enter START.
REQ-016 START: at tick_cnt==0, SHALL sample rx_s; 0 -> DATA, tick_cnt=div, bit index=0; 1 -> IDLE (glitch rejected, nothing recorded).
REQ-017 tick_cnt SHALL decrement by 1 each cycle when non-zero in START/DATA/STOP.
REQ-018 DATA: at tick_cnt==0, SHALL shift rx_s into shift register MSB (right-shift, LSB-first), reload tick_cnt=div; after 8th bit enter STOP.
REQ-019 STOP: at tick_cnt==0 with rx_s==1, SHALL push byte to FIFO and enter IDLE in the same cycle.
REQ-020 STOP: at tick_cnt==0 with rx_s==0, SHALL discard byte, set frame_err, enter WAIT_IDLE.
REQ-021 WAIT_IDLE: SHALL remain until rx_s==1 (break/stuck-low tolerance), then IDLE.
REQ-022 Pushed byte SHALL appear on rx_data with rx_valid=1 exactly one cycle after the stop-bit sample when FIFO was empty.
REQ-023 FIFO SHALL be first-word-fall-through; rx_data valid whenever rx_valid=1; rx_data undefined-but-stable when empty.
REQ-024 Push with FIFO full and no pop SHALL drop the new byte, keep FIFO contents, set overrun.
REQ-025 Push and pop in the same cycle when full SHALL both succeed; count unchanged; no overrun.
REQ-026 Push and pop in the same cycle when empty SHALL NOT bypass; count becomes 1, byte visible next cycle.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL saturate at FIFO_DEPTH and never underflow (pop when empty ignored).
REQ-028 Error set and err_clr in the same cycle: set SHALL win.
REQ-029 div changes outside IDLE SHALL NOT affect the frame in progress.

Reset
REQ-030 On rst=1 at posedge clk: state=IDLE, synchronizer flops=1, tick_cnt=0, bit index=0, FIFO pointers=0, count=0, rx_valid=0, rx_data=0, frame_err=0, overrun=0.
REQ-031 rst mid-frame SHALL abort the frame with no push and no error; FIFO contents discarded.
REQ-032 After rst release, a line held low SHALL be treated as a start edge only after rx_s is low (synchronizer reset high prevents false start for 2 cycles).

Verification
REQ-033 div=15, drive 0xA5 8N1 at 16 clk/bit, rx_ready=0 -> rx_valid=1, rx_data=0xA5, count=1, no error flags.
REQ-034 div=15, send 0x00 with stop bit low, then line high -> frame_err=1, count=0; err_clr pulse -> frame_err=0 next cycle.
REQ-035 FIFO_DEPTH=4, rx_ready=0, send 0x11,0x22,0x33,0x44,0x55 -> count=4, overrun=1, pops yield 0x11,0x22,0x33,0x44 in order.
REQ-036 div=15, 3-cycle low glitch on RX -> returns to IDLE, count=0, frame_err=0.
REQ-037 rst asserted at bit 4 of a 0x3C frame, then clean 0x7E sent -> only 0x7E received, count=1.
REQ-038 FIFO full, rx_ready=1 held while 0x99 stop bit sampled -> count stays 4, overrun=0, 0x99 later read last.
